// File: rtl/mealy_pkg.sv
// Shared types and the transition-table builder for mealy_seq_detector.
// The overlap mode is chosen by the MEALY_OVERLAP_EN macro in the top module.
package mealy_pkg;

    localparam int MAX_PAT_W = 16;
    localparam int S_IDLE    = 0;

    typedef logic [$clog2(MAX_PAT_W)-1:0] state_t;

    // Next state of the detector: the longest prefix of the pattern that is a suffix of
    // (prefix of length state, b). A full match yields the longest proper border if
    // overlapping, or S_IDLE otherwise. Evaluated only at elaboration.
    function automatic int next_state(input logic [MAX_PAT_W-1:0] pattern,
                                      input int pat_w, input int state,
                                      input logic b, input logic overlap);
        logic [MAX_PAT_W-1:0] s;
        int len;
        int max_k;
        int best;
        logic ok;
        if (state >= pat_w) return S_IDLE;
        if (state == pat_w - 1 && b == pattern[0] && !overlap) return S_IDLE;
        len = state + 1;
        s = '0;
        for (int i = 0; i < MAX_PAT_W; i++) begin
            if (i < len - 1) s[i] = pattern[pat_w-1-i];
        end
        s[len-1] = b;
        // States only reach PAT_W-1, so a full-length match folds back onto a border.
        max_k = (len < pat_w) ? len : pat_w - 1;
        best = S_IDLE;
        for (int k = 1; k <= MAX_PAT_W; k++) begin
            if (k <= max_k) begin
                ok = 1'b1;
                for (int j = 0; j < MAX_PAT_W; j++) begin
                    if (j < k && s[len-k+j] != pattern[pat_w-1-j]) ok = 1'b0;
                end
                if (ok) best = k;
            end
        end
        return best;
    endfunction

endpackage

// File: rtl/mealy_seq_detector.sv
// Mealy serial pattern detector; dout is combinational in the current state and d.
// Define MEALY_OVERLAP_EN for overlapping detection, leave undefined for non-overlapping.
module mealy_seq_detector
    import mealy_pkg::*;
#(
    parameter int                 PAT_W   = 4,
    parameter logic [PAT_W-1:0]   PATTERN = 4'b1011
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic dout
);

`ifdef MEALY_OVERLAP_EN
    localparam logic OVERLAP = 1'b1;
`else
    localparam logic OVERLAP = 1'b0;
`endif

    localparam int              SW      = $clog2(PAT_W);
    localparam int              NST     = 2 ** SW;
    localparam logic [SW-1:0]   LAST_ST = SW'(PAT_W - 1);
    localparam logic [MAX_PAT_W-1:0] PAT16 = MAX_PAT_W'(PATTERN);

    logic [SW-1:0] state_q;
    logic [SW-1:0] state_d;
    logic [SW-1:0] ns_tbl [2*NST];

    // Entry {state, bit}; unreachable encodings beyond PAT_W-1 fall back to idle.
    for (genvar gi = 0; gi < NST; gi++) begin : g_st
        for (genvar gb = 0; gb < 2; gb++) begin : g_bit
            localparam int NS = next_state(PAT16, PAT_W, gi, (gb != 0), OVERLAP);
            assign ns_tbl[2*gi+gb] = SW'(NS);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= SW'(S_IDLE);
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = ns_tbl[{state_q, d}];
        dout    = rst && (state_q == LAST_ST) && (d == PATTERN[0]);
    end

endmodule

// File: tb/tb_mealy_seq_detector.sv
// Directed bench for mealy_seq_detector: default 1011 instance plus a 3-bit 110 instance.
// Expectations follow MEALY_OVERLAP_EN so the bench works in either build.
module tb_mealy_seq_detector;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic d   = 1'b0;
    logic d3  = 1'b0;
    logic dout;
    logic dout3;

    always #10 clk = ~clk;

    mealy_seq_detector dut (.clk(clk), .rst(rst), .d(d), .dout(dout));

    mealy_seq_detector #(.PAT_W(3), .PATTERN(3'b110)) dut3 (
        .clk(clk), .rst(rst), .d(d3), .dout(dout3)
    );

`ifdef MEALY_OVERLAP_EN
    localparam logic OVL = 1'b1;
`else
    localparam logic OVL = 1'b0;
`endif

    typedef struct {
        logic d;
        logic exp;
    } vec_t;

    vec_t stream [19];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: dout=%b expected %b", name, act, exp);
        end else begin
            $display("[TB] %s: dout=%b ok", name, act);
        end
    endtask

    // Present one bit on the falling edge and check dout before the rising edge.
    task automatic bit4(input string name, input logic b, input logic exp);
        @(negedge clk);
        d = b;
        #1;
        check(name, dout, exp);
    endtask

    task automatic bit3(input string name, input logic b, input logic exp);
        @(negedge clk);
        d3 = b;
        #1;
        check(name, dout3, exp);
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        rst = 1'b0;
        d   = 1'b1;
        d3  = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            #1;
            check($sformatf("reset_c%0d", i), dout, 1'b0);
            @(negedge clk);
        end
        rst = 1'b1;
        d   = 1'b0;
    endtask

    initial begin
        logic [18:0] sb;
        logic [18:0] se;
        logic [1:0]  hist;
        int          cnt;
        logic        b;
        logic        e;

        sb = 19'b1100101001101101101;
        se = OVL ? 19'b0000000000000100100 : 19'b0000000000000100000;
        for (int i = 0; i < 19; i++) begin
            stream[i].d   = sb[18-i];
            stream[i].exp = se[18-i];
        end

        // Reset with d=1 held, then release and detect from S0.
        do_reset(2);
        bit4("post_rst_b1", 1'b1, 1'b0);
        bit4("post_rst_b2", 1'b0, 1'b0);
        bit4("post_rst_b3", 1'b1, 1'b0);
        bit4("post_rst_b4", 1'b1, 1'b1);

        do_reset(1);
        for (int i = 0; i < 19; i++)
            bit4($sformatf("stream_i%0d", i), stream[i].d, stream[i].exp);

        // 1011011: second pulse only when overlapping.
        do_reset(1);
        bit4("ovl_b1", 1'b1, 1'b0);
        bit4("ovl_b2", 1'b0, 1'b0);
        bit4("ovl_b3", 1'b1, 1'b0);
        bit4("ovl_b4", 1'b1, 1'b1);
        bit4("ovl_b5", 1'b0, 1'b0);
        bit4("ovl_b6", 1'b1, 1'b0);
        bit4("ovl_b7", 1'b1, OVL);

        // Reset mid-pattern discards the partial 101.
        do_reset(1);
        bit4("mid_b1", 1'b1, 1'b0);
        bit4("mid_b2", 1'b0, 1'b0);
        bit4("mid_b3", 1'b1, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        d   = 1'b1;
        #1;
        check("mid_rst_forced", dout, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        d   = 1'b1;
        #1;
        check("mid_after_1", dout, 1'b0);
        bit4("mid_after_0", 1'b0, 1'b0);
        bit4("mid_after_1b", 1'b1, 1'b0);
        bit4("mid_after_1c", 1'b1, 1'b1);

        // Mealy property: in S3, dout tracks d within one low phase.
        do_reset(1);
        bit4("mealy_b1", 1'b1, 1'b0);
        bit4("mealy_b2", 1'b0, 1'b0);
        bit4("mealy_b3", 1'b1, 1'b0);
        @(negedge clk);
        d = 1'b0; #1; check("mealy_d0", dout, 1'b0);
        #2; d = 1'b1; #1; check("mealy_d1", dout, 1'b1);
        #2; d = 1'b0; #1; check("mealy_d0b", dout, 1'b0);
        #1; d = 1'b1; #1; check("mealy_d1b", dout, 1'b1);

        // 3-bit pattern 110.
        do_reset(1);
        bit3("p3_b1", 1'b1, 1'b0);
        bit3("p3_b2", 1'b1, 1'b0);
        bit3("p3_b3", 1'b1, 1'b0);
        bit3("p3_b4", 1'b0, 1'b1);

        // Random stream against a shift-register model with a since-match counter.
        do_reset(1);
        hist = 2'b00;
        cnt  = 0;
        for (int i = 0; i < 1000; i++) begin
            b = 1'($urandom_range(0, 1));
            e = (cnt >= 2) && ({hist, b} == 3'b110);
            bit3($sformatf("rnd_i%0d", i), b, e);
            hist = {hist[0], b};
            if (e && !OVL) cnt = 0;
            else if (cnt < 2) cnt++;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mealy_seq_detector.md
# mealy_seq_detector

Serial-bit pattern detector built as a Mealy finite-state machine. It samples one input bit per clock and asserts a combinational match flag in the same cycle the final bit of a programmable pattern is presented. The default pattern is 1011. The block sits between a serial bit source and any logic that reacts to a frame or marker on that stream. The module name is `mealy_seq_detector`, and the default build is drop-in compatible with the existing `mealy` port list.

## Interface
Parameters:
- PAT_W, 4: pattern length in bits; legal range 2..16.
- PATTERN, 4'b1011: pattern to detect. PATTERN[PAT_W-1] is the first bit received, PATTERN[0] the last.

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- rst  input  1  reset; asynchronous assert, active-low. rst=0 resets the state immediately; rst=1 allows normal operation.
- d  input  1  serial data bit; sampled on the rising clk edge.
- dout  output  1  match flag, Mealy: a combinational function of the current state and d.

## Operation
- State encoding: state k, for k = 0..PAT_W-1, means the longest suffix of the received bits that is also a prefix of PATTERN has length k.
- Default 1011, with overlap, uses states S0 (none), S1 ("1"), S2 ("10"), S3 ("101"):
  - S0: d=1 → S1; d=0 → S0.
  - S1: d=1 → S1; d=0 → S2.
  - S2: d=1 → S3; d=0 → S0.
  - S3: d=1 → S1 with dout=1; d=0 → S2.
- dout=1 only when state = PAT_W-1 and d = PATTERN[0]; in every other state/input combination dout=0.
- Generic next-state: the longest proper prefix of PATTERN that is a suffix of (received bits, d), in failure-function (KMP) style. The table is computed at elaboration by a constant function; no runtime cost.
- Full match:
  - With overlap, the next state is the longest proper border of PATTERN; for 1011 that is S1.
  - Without overlap, the next state is S0.
- Reset: while rst=0, state = S0 and dout is forced to 0 regardless of d.
- Reset mid-pattern discards partial progress; detection restarts from S0 after release.
- X on d: no requirement beyond simulation propagation.

## Timing
- dout reflects d in the same cycle, with zero latency from d. The downstream consumer must sample dout on the same rising edge that the FSM uses to consume d.
- State updates on the rising clk edge, one bit per cycle. There is no handshake and no valid qualifier; every clock is a data bit.
- Reset assertion is asynchronous.
- Reset deassertion must meet recovery/removal timing. The first bit consumed is the one sampled at the first rising edge with rst=1.
- dout can glitch as d changes. The stimulus source changes d on the falling edge.

## Configuration
- MEALY_OVERLAP_EN:
  - Defined: overlapping detection; after a full match the FSM continues from the longest border. For 1011, input 1011011 produces two pulses.
  - Undefined: non-overlapping detection; after a full match the FSM returns to S0. For 1011, input 1011011 produces one pulse.
- The default build defines MEALY_OVERLAP_EN.

## Structure
- Shared package `mealy_pkg`:
  - state type sized $clog2(PAT_W);
  - constant S_IDLE = 0;
  - constant function `next_state(pattern, pat_w, state, bit, overlap)` computing the transition table.
- No sub-module. Use one sequential block (state register with asynchronous reset) and one combinational block (next state and dout).

## Test plan
- Reset behaviour: hold rst=0 for 2 cycles with d=1 → dout=0 throughout and state=S0. Release rst to 1 → detection starts at S0.
- Default stream: release reset, then apply d = 1,1,0,0,1,0,1,0,0,1,1,0,1,1,0,1,1,0,1, one bit per cycle, changing on falling edges. dout pulses exactly twice:
  - while bit index 13 (d=1) is applied;
  - while bit index 16 (d=1) is applied.
  - dout is 0 at every other index.
- Overlap check: apply 1011011 → pulses on bits 4 and 7 with MEALY_OVERLAP_EN; only on bit 4 without it.
- Reset mid-pattern: apply 1,0,1, then rst=0 for one cycle, then 1 → no pulse. Follow with 0,1,1 → pulse on the final 1.
- Parameter sweep: PAT_W=3, PATTERN=3'b110; apply 1,1,1,0 → pulse only on the final 0. Compare against a shift-register reference model on 1000 random bits.
- Mealy property: while in S3 (after 101), toggle d between 0 and 1 mid-cycle → dout follows d combinationally, before any clock edge.
